// File: rtl/fan_speed_ctrl_if.sv
// Sample/level bus between the temperature sensor front end and fan_speed_ctrl.
// The master drives temperature samples; the slave (controller) returns the fan level and status flags.
interface fan_speed_ctrl_if;
    logic       temp_valid;
    logic [7:0] temp_data;
    logic [2:0] fanspeed;
    logic       over_temp;
    logic       sensor_fault;
    logic       level_chg;

    modport master (
        output temp_valid, temp_data,
        input  fanspeed, over_temp, sensor_fault, level_chg
    );

    modport slave (
        input  temp_valid, temp_data,
        output fanspeed, over_temp, sensor_fault, level_chg
    );
endinterface

// File: rtl/fan_speed_ctrl.sv
// Temperature-to-fan-level controller with hysteresis, dwell, over-temp and sensor-timeout fail-safe.
// Optional macro FAN_RAMP_LIMIT_EN: applied level changes move one step at a time.
//
// state   | meaning
// S_INIT  | after reset, fan at full speed, waiting for the first sample
// S_RUN   | normal threshold/hysteresis/dwell control
// S_FAULT | no sample within TIMEOUT_CYCLES, fan forced to full speed
module fan_speed_ctrl #(
    parameter logic [7:0]  T1             = 8'd40,
    parameter logic [7:0]  T2             = 8'd50,
    parameter logic [7:0]  T3             = 8'd60,
    parameter logic [7:0]  T4             = 8'd70,
    parameter logic [7:0]  T_CRIT         = 8'd85,
    parameter logic [7:0]  HYST           = 8'd3,
    parameter int          DWELL_SAMPLES  = 4,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic             CLK,
    input  logic             RST,
    fan_speed_ctrl_if.slave  bus
);
    localparam int DW_W = $clog2(DWELL_SAMPLES + 1);

    // Falling thresholds saturate at zero so a small Tk never wraps to a huge value.
    localparam logic [7:0] D1 = (T1 > HYST) ? T1 - HYST : 8'd0;
    localparam logic [7:0] D2 = (T2 > HYST) ? T2 - HYST : 8'd0;
    localparam logic [7:0] D3 = (T3 > HYST) ? T3 - HYST : 8'd0;
    localparam logic [7:0] D4 = (T4 > HYST) ? T4 - HYST : 8'd0;

    typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

    state_t          state;
    dir_t            dir_q, dir_d;
    logic [DW_W-1:0] dwell_cnt, dwell_d, dwell_inc;
    logic [23:0]     tcnt;
    logic [2:0]      lup, ldn, step_lvl, run_lvl;
    logic            up_c, dn_c, crit, same_dir, apply;

    always_comb begin
        lup = {2'b00, bus.temp_data >= T1} + {2'b00, bus.temp_data >= T2}
            + {2'b00, bus.temp_data >= T3} + {2'b00, bus.temp_data >= T4};
        ldn = {2'b00, bus.temp_data >= D1} + {2'b00, bus.temp_data >= D2}
            + {2'b00, bus.temp_data >= D3} + {2'b00, bus.temp_data >= D4};
        crit      = bus.temp_data >= T_CRIT;
        up_c      = lup > bus.fanspeed;
        dn_c      = !up_c && (ldn < bus.fanspeed);
        same_dir  = (up_c && dir_q == DIR_UP) || (dn_c && dir_q == DIR_DN);
        dwell_inc = same_dir ? dwell_cnt + DW_W'(1) : DW_W'(1);
        apply     = (up_c || dn_c) && (dwell_inc == DW_W'(DWELL_SAMPLES));
`ifdef FAN_RAMP_LIMIT_EN
        step_lvl  = up_c ? bus.fanspeed + 3'd1 : bus.fanspeed - 3'd1;
`else
        step_lvl  = up_c ? lup : ldn;
`endif
        run_lvl = bus.fanspeed;
        dwell_d = '0;
        dir_d   = DIR_NONE;
        if (crit) begin
            run_lvl = 3'd4;
        end else if (apply) begin
            run_lvl = step_lvl;
        end else if (up_c || dn_c) begin
            dwell_d = dwell_inc;
            dir_d   = up_c ? DIR_UP : DIR_DN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state            <= S_INIT;
            bus.fanspeed     <= 3'd4;
            bus.over_temp    <= 1'b0;
            bus.sensor_fault <= 1'b0;
            bus.level_chg    <= 1'b0;
            dwell_cnt        <= '0;
            dir_q            <= DIR_NONE;
            tcnt             <= '0;
        end else begin
            bus.level_chg <= 1'b0;
            // A sample always wins over the timeout, and is evaluated the same way from any state.
            if (bus.temp_valid) begin
                state            <= S_RUN;
                bus.sensor_fault <= 1'b0;
                tcnt             <= '0;
                bus.over_temp    <= crit;
                bus.fanspeed     <= run_lvl;
                bus.level_chg    <= (run_lvl != bus.fanspeed);
                dwell_cnt        <= dwell_d;
                dir_q            <= dir_d;
            end else if (state != S_FAULT) begin
                if (tcnt == TIMEOUT_CYCLES - 24'd1) begin
                    state            <= S_FAULT;
                    bus.sensor_fault <= 1'b1;
                    bus.fanspeed     <= 3'd4;
                    bus.level_chg    <= (bus.fanspeed != 3'd4);
                    dwell_cnt        <= '0;
                    dir_q            <= DIR_NONE;
                    tcnt             <= '0;
                end else begin
                    tcnt <= tcnt + 24'd1;
                end
            end
        end
    end
endmodule
